cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the single Common Data Bus (CDB) between the execution units' writeback stages.
- Requesters: ALU = 0, branch unit = 1, LSU = 2.
- Each cycle it grants at most one valid requester, round-robin, and registers the winner onto the CDB.
- Every losing valid requester gets a per-requester stall; the LSU's i_stall is driven from this block.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- DATA_WIDTH, 32, result data width.
- PREG_WIDTH, 7, physical destination register tag width.
- ROB_WIDTH, 4, ROB tag width.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- i_flush  input  1  mispredict flush; kills the CDB output and the current cycle's grant.
- i_req_valid  input  NUM_REQ  bit i = requester i has a result.
- i_req_data  input  NUM_REQ*DATA_WIDTH  result data; requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- i_req_prd  input  NUM_REQ*PREG_WIDTH  destination preg per requester, same packing.
- i_req_rob_tag  input  NUM_REQ*ROB_WIDTH  ROB tag per requester, same packing.
- o_stall  output  NUM_REQ  bit i high = requester i must hold its pipeline this cycle.
- o_grant  output  NUM_REQ  one-hot (or zero) combinational grant this cycle.
- o_cdb_valid  output  1  CDB broadcast valid.
- o_cdb_data  output  DATA_WIDTH  broadcast result.
- o_cdb_prd  output  PREG_WIDTH  broadcast destination preg.
- o_cdb_rob_tag  output  ROB_WIDTH  broadcast ROB tag.

Behaviour:
- State:
  - rr_ptr: $clog2(NUM_REQ) bits, the highest-priority index.
  - CDB output register: valid, data, prd, rob_tag.
- Reset: rr_ptr = 0, o_cdb_valid = 0, o_cdb_data/prd/rob_tag = 0. Combinationally, o_stall = 0 and o_grant = 0 while reset is high.
- Grant (combinational):
  - Scan i_req_valid starting at rr_ptr, increasing index, wrapping from NUM_REQ-1 to 0.
  - The first set bit wins; o_grant is one-hot on the winner.
  - If no request is valid, o_grant = 0.
- Stall (combinational): o_stall[i] = i_req_valid[i] & ~o_grant[i]. A requester with no valid result is never stalled.
- Latency: the granted fields appear on the o_cdb_* outputs one cycle after the grant. A stalled requester keeps its fields stable until it is granted.
- CDB register, next cycle:
  - Granted: o_cdb_valid = 1 and the winner's data/prd/rob_tag are captured.
  - Not granted: o_cdb_valid = 0; data/prd/rob_tag hold their previous values.
- Pointer update:
  - On a grant to index g, rr_ptr becomes (g+1) mod NUM_REQ, with explicit wrap (NUM_REQ need not be a power of two).
  - With no grant, rr_ptr holds.
- Fairness: a continuously valid requester waits at most NUM_REQ-1 cycles.
- Flush (i_flush = 1), same cycle:
  - o_grant = 0 and o_stall = 0, so requesters are released and flush themselves.
  - Next cycle: o_cdb_valid = 0; rr_ptr holds.
- Precedence: reset has priority over flush; flush has priority over grant.
- Single requester valid: granted every cycle, never stalled, back-to-back CDB valid.
- rr_ptr value outside 0..NUM_REQ-1 cannot occur. An assertion checks this, plus grant one-hotness and grant ⊆ valid.

Optional Feature:
- Macro: CDB_ARB_PERF_EN.
- Defined: adds outputs o_grant_count and o_stall_count, each NUM_REQ*32 bits.
  - Per-requester 32-bit saturating counters: grants, and cycles with o_stall set.
  - Cleared by reset; unaffected by flush.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package cdb_pkg:
  - cdb_entry_t packed struct {valid, data, prd, rob_tag}.
  - Requester index constants REQ_ALU = 0, REQ_BRANCH = 1, REQ_LSU = 2.
  - Default width localparams.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req, ptr. Output: one-hot grant.
  - Purely combinational.
  - cdb_arbiter owns rr_ptr and the CDB register.

Test Plan:
- Reset: after reset, with all i_req_valid = 0 → o_cdb_valid = 0, o_stall = 000, rr_ptr = 0.
- Single LSU stream: i_req_valid = 100 for 4 cycles, rob_tag 1..4 → o_stall[2] = 0 throughout; CDB shows rob_tag 1,2,3,4 on consecutive cycles, each one cycle late.
- All contend: i_req_valid = 111 held, from rr_ptr = 0 → grants 0,1,2,0,1,2. o_stall = 110, 101, 011 repeating. CDB order ALU, BR, LSU.
- Wrap: rr_ptr = 2 and requests 011 → grant 0 (not 1); rr_ptr becomes 1; the next cycle grants 1.
- Flush: i_req_valid = 111 with i_flush = 1 → o_grant = 000, o_stall = 000; next cycle o_cdb_valid = 0; rr_ptr unchanged.
- Perf (CDB_ARB_PERF_EN): the contend scenario for 6 cycles → o_grant_count = 2 per requester; o_stall_count = 4 per requester.

Source files
------------

// File: rtl/cdb_pkg.sv
// cdb_pkg: shared definitions for the Common Data Bus arbiter.
// Holds default widths, requester index constants and the CDB entry layout
// as seen by consumers built at the default widths.
package cdb_pkg;

    localparam int CDB_NUM_REQ    = 3;
    localparam int CDB_DATA_WIDTH = 32;
    localparam int CDB_PREG_WIDTH = 7;
    localparam int CDB_ROB_WIDTH  = 4;

    // Writeback requester indices on the arbiter's request vector.
    localparam int REQ_ALU    = 0;
    localparam int REQ_BRANCH = 1;
    localparam int REQ_LSU    = 2;

    typedef struct packed {
        logic                      valid;
        logic [CDB_DATA_WIDTH-1:0] data;
        logic [CDB_PREG_WIDTH-1:0] prd;
        logic [CDB_ROB_WIDTH-1:0]  rob_tag;
    } cdb_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin pick.
// Scans req starting at ptr with increasing index, wrapping from N-1 to 0,
// and returns a one-hot grant on the first set bit (zero if none).
module rr_arbiter #(
    parameter  int N     = 3,
    localparam int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    int   idx;
    logic found;

    // First valid requester at or after ptr (with explicit wrap) wins.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write so no latch is inferred.
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[PTR_W'(idx)]) begin
                grant[PTR_W'(idx)] = 1'b1;
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the Common Data Bus between writeback requesters.
// Round-robin grant each cycle, winner registered onto the CDB one cycle
// later, losers stalled. Reset outranks flush, flush outranks grant.
// Optional macro CDB_ARB_PERF_EN adds per-requester saturating grant and
// stall counters (o_grant_count / o_stall_count).
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_REQ    = CDB_NUM_REQ,
    parameter int DATA_WIDTH = CDB_DATA_WIDTH,
    parameter int PREG_WIDTH = CDB_PREG_WIDTH,
    parameter int ROB_WIDTH  = CDB_ROB_WIDTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_flush,
    input  logic [NUM_REQ-1:0]              i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_data,
    input  logic [NUM_REQ*PREG_WIDTH-1:0]   i_req_prd,
    input  logic [NUM_REQ*ROB_WIDTH-1:0]    i_req_rob_tag,
    output logic [NUM_REQ-1:0]              o_stall,
    output logic [NUM_REQ-1:0]              o_grant,
    output logic                            o_cdb_valid,
    output logic [DATA_WIDTH-1:0]           o_cdb_data,
    output logic [PREG_WIDTH-1:0]           o_cdb_prd,
    output logic [ROB_WIDTH-1:0]            o_cdb_rob_tag
`ifdef CDB_ARB_PERF_EN
    ,
    output logic [NUM_REQ*32-1:0]           o_grant_count,
    output logic [NUM_REQ*32-1:0]           o_stall_count
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);

    // CDB register at this instance's widths (matches cdb_entry_t at defaults).
    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] data;
        logic [PREG_WIDTH-1:0] prd;
        logic [ROB_WIDTH-1:0]  rob_tag;
    } cdb_reg_t;

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    cdb_reg_t           cdb_q, cdb_d;
    logic [NUM_REQ-1:0] grant_raw;
    logic               kill;

    rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
        .req   (i_req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant_raw)
    );

    // Gate grant and stall: reset or flush releases every requester this cycle.
    always_comb begin
        kill    = reset | i_flush;
        o_grant = kill ? '0 : grant_raw;
        o_stall = kill ? '0 : (i_req_valid & ~grant_raw);
    end

    // Next CDB contents and round-robin pointer from this cycle's grant.
    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        cdb_d         = cdb_q;
        cdb_d.valid   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (o_grant[i]) begin
                cdb_d.valid   = 1'b1;
                cdb_d.data    = i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
                cdb_d.prd     = i_req_prd[i*PREG_WIDTH +: PREG_WIDTH];
                cdb_d.rob_tag = i_req_rob_tag[i*ROB_WIDTH +: ROB_WIDTH];
                // Explicit wrap: NUM_REQ need not be a power of two.
                rr_ptr_d      = (i == NUM_REQ-1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    // Pointer and CDB register, synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            rr_ptr_q <= '0;
            cdb_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            cdb_q    <= cdb_d;
        end
    end

    assign o_cdb_valid   = cdb_q.valid;
    assign o_cdb_data    = cdb_q.data;
    assign o_cdb_prd     = cdb_q.prd;
    assign o_cdb_rob_tag = cdb_q.rob_tag;

`ifdef CDB_ARB_PERF_EN
    logic [31:0] grant_cnt_q [NUM_REQ];
    logic [31:0] grant_cnt_d [NUM_REQ];
    logic [31:0] stall_cnt_q [NUM_REQ];
    logic [31:0] stall_cnt_d [NUM_REQ];

    // Saturating per-requester grant and stall-cycle counters.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt_d[i] = grant_cnt_q[i];
            stall_cnt_d[i] = stall_cnt_q[i];
            if (o_grant[i] && (grant_cnt_q[i] != '1)) begin
                grant_cnt_d[i] = grant_cnt_q[i] + 32'd1;
            end
            if (o_stall[i] && (stall_cnt_q[i] != '1)) begin
                stall_cnt_d[i] = stall_cnt_q[i] + 32'd1;
            end
        end
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reset) begin
                grant_cnt_q[i] <= '0;
                stall_cnt_q[i] <= '0;
            end else begin
                grant_cnt_q[i] <= grant_cnt_d[i];
                stall_cnt_q[i] <= stall_cnt_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf_out
        assign o_grant_count[g*32 +: 32] = grant_cnt_q[g];
        assign o_stall_count[g*32 +: 32] = stall_cnt_q[g];
    end
`endif

    // Structural invariants of the arbiter.
    a_ptr_range: assert property (@(posedge clk) disable iff (reset)
        int'(rr_ptr_q) < NUM_REQ);
    a_grant_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0(o_grant));
    a_grant_subset: assert property (@(posedge clk) disable iff (reset)
        (o_grant & ~i_req_valid) == '0);

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed self-checking bench for cdb_arbiter at default
// widths (3 requesters). Inputs change 1ns after the rising edge; outputs
// are sampled 1-2ns after the edge.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int PW = 7;
    localparam int RW = 4;

    logic            clk;
    logic            reset;
    logic            i_flush;
    logic [N-1:0]    i_req_valid;
    logic [N*DW-1:0] i_req_data;
    logic [N*PW-1:0] i_req_prd;
    logic [N*RW-1:0] i_req_rob_tag;
    logic [N-1:0]    o_stall;
    logic [N-1:0]    o_grant;
    logic            o_cdb_valid;
    logic [DW-1:0]   o_cdb_data;
    logic [PW-1:0]   o_cdb_prd;
    logic [RW-1:0]   o_cdb_rob_tag;
`ifdef CDB_ARB_PERF_EN
    logic [N*32-1:0] o_grant_count;
    logic [N*32-1:0] o_stall_count;
    logic [31:0]     gc0 [N];
    logic [31:0]     sc0 [N];
`endif

    logic [DW-1:0] data_a [N];
    logic [PW-1:0] prd_a  [N];
    logic [RW-1:0] rob_a  [N];

    int checks;
    int failures;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign i_req_data[g*DW +: DW]    = data_a[g];
        assign i_req_prd[g*PW +: PW]     = prd_a[g];
        assign i_req_rob_tag[g*RW +: RW] = rob_a[g];
    end

    cdb_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .PREG_WIDTH (PW),
        .ROB_WIDTH  (RW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_flush       (i_flush),
        .i_req_valid   (i_req_valid),
        .i_req_data    (i_req_data),
        .i_req_prd     (i_req_prd),
        .i_req_rob_tag (i_req_rob_tag),
        .o_stall       (o_stall),
        .o_grant       (o_grant),
        .o_cdb_valid   (o_cdb_valid),
        .o_cdb_data    (o_cdb_data),
        .o_cdb_prd     (o_cdb_prd),
        .o_cdb_rob_tag (o_cdb_rob_tag)
`ifdef CDB_ARB_PERF_EN
        ,
        .o_grant_count (o_grant_count),
        .o_stall_count (o_stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [N-1:0] exp_g;
        int           g;
        checks   = 0;
        failures = 0;
        reset       = 1'b1;
        i_flush     = 1'b0;
        i_req_valid = '0;
        for (int i = 0; i < N; i++) begin
            data_a[i] = '0;
            prd_a[i]  = '0;
            rob_a[i]  = '0;
        end

        // Reset gates grant and stall combinationally.
        tick();
        i_req_valid = 3'b111;
        #1;
        check("reset_grant", 64'(o_grant), 64'h0);
        check("reset_stall", 64'(o_stall), 64'h0);
        tick();
        reset       = 1'b0;
        i_req_valid = 3'b000;
        #1;
        check("reset_cdb_valid", 64'(o_cdb_valid), 64'h0);
        check("reset_cdb_data",  64'(o_cdb_data), 64'h0);
        check("reset_cdb_rob",   64'(o_cdb_rob_tag), 64'h0);
        check("reset_stall_idle", 64'(o_stall), 64'h0);
        check("reset_rr_ptr",    64'(dut.rr_ptr_q), 64'h0);

        // Single LSU stream: granted every cycle, never stalled.
        for (int k = 1; k <= 4; k++) begin
            i_req_valid    = 3'b100;
            rob_a[REQ_LSU]  = RW'(k);
            data_a[REQ_LSU] = 32'h1000 + 32'(k);
            prd_a[REQ_LSU]  = PW'(40 + k);
            #1;
            check("lsu_stall", 64'(o_stall), 64'h0);
            check("lsu_grant", 64'(o_grant), 64'h4);
            tick();
            check("lsu_cdb_valid", 64'(o_cdb_valid), 64'h1);
            check("lsu_cdb_rob",   64'(o_cdb_rob_tag), 64'(k));
            check("lsu_cdb_data",  64'(o_cdb_data), 64'h1000 + 64'(k));
            check("lsu_cdb_prd",   64'(o_cdb_prd), 64'(40 + k));
        end
        i_req_valid = 3'b000;
        tick();
        check("idle_cdb_valid", 64'(o_cdb_valid), 64'h0);
        check("idle_cdb_rob_hold", 64'(o_cdb_rob_tag), 64'h4);
        check("idle_rr_ptr", 64'(dut.rr_ptr_q), 64'h0);

`ifdef CDB_ARB_PERF_EN
        for (int i = 0; i < N; i++) begin
            gc0[i] = o_grant_count[i*32 +: 32];
            sc0[i] = o_stall_count[i*32 +: 32];
        end
`endif

        // All contend from rr_ptr = 0: grants 0,1,2,0,1,2.
        for (int i = 0; i < N; i++) begin
            data_a[i] = 32'hD0 + 32'(i);
            rob_a[i]  = RW'(8 + i);
            prd_a[i]  = PW'(16 + i);
        end
        i_req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            g     = k % 3;
            exp_g = 3'b001 << g;
            #1;
            check("contend_grant", 64'(o_grant), 64'(exp_g));
            check("contend_stall", 64'(o_stall), 64'(3'b111 & ~exp_g));
            tick();
            check("contend_cdb_valid", 64'(o_cdb_valid), 64'h1);
            check("contend_cdb_rob",   64'(o_cdb_rob_tag), 64'(8 + g));
            check("contend_cdb_data",  64'(o_cdb_data), 64'hD0 + 64'(g));
        end
        check("contend_rr_ptr", 64'(dut.rr_ptr_q), 64'h0);
`ifdef CDB_ARB_PERF_EN
        for (int i = 0; i < N; i++) begin
            check("perf_grant_delta", 64'(o_grant_count[i*32 +: 32] - gc0[i]), 64'd2);
            check("perf_stall_delta", 64'(o_stall_count[i*32 +: 32] - sc0[i]), 64'd4);
        end
`endif

        // Wrap: move pointer to 2, then requests 011 must grant 0 first.
        i_req_valid = 3'b010;
        #1;
        check("wrap_setup_grant", 64'(o_grant), 64'h2);
        tick();
        check("wrap_setup_ptr", 64'(dut.rr_ptr_q), 64'h2);
        i_req_valid = 3'b011;
        #1;
        check("wrap_grant0", 64'(o_grant), 64'h1);
        check("wrap_stall0", 64'(o_stall), 64'h2);
        tick();
        check("wrap_ptr1", 64'(dut.rr_ptr_q), 64'h1);
        check("wrap_cdb_rob0", 64'(o_cdb_rob_tag), 64'h8);
        #1;
        check("wrap_grant1", 64'(o_grant), 64'h2);
        tick();
        check("wrap_ptr2", 64'(dut.rr_ptr_q), 64'h2);
        check("wrap_cdb_rob1", 64'(o_cdb_rob_tag), 64'h9);

        // Flush: kills grant and stall, CDB invalid next cycle, pointer holds.
        i_req_valid = 3'b111;
        i_flush     = 1'b1;
        #1;
        check("flush_grant", 64'(o_grant), 64'h0);
        check("flush_stall", 64'(o_stall), 64'h0);
        tick();
        check("flush_cdb_valid", 64'(o_cdb_valid), 64'h0);
        check("flush_rr_ptr", 64'(dut.rr_ptr_q), 64'h2);
        check("flush_cdb_rob_hold", 64'(o_cdb_rob_tag), 64'h9);
        i_flush = 1'b0;
        #1;
        check("post_flush_grant", 64'(o_grant), 64'h4);
        check("post_flush_stall", 64'(o_stall), 64'h3);
        tick();
        check("post_flush_cdb_valid", 64'(o_cdb_valid), 64'h1);
        check("post_flush_cdb_rob", 64'(o_cdb_rob_tag), 64'hA);
        check("post_flush_rr_ptr", 64'(dut.rr_ptr_q), 64'h0);

        i_req_valid = 3'b000;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
